piso_tx: RTL and testbench

//  Parallel-in/serial-out frame transmitter; transmit end of the serial link whose receive end is the SIPO.

---
 rtl/piso_tx.sv | 133 +++++++++++++
 tb/tb_piso_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, data MSB-first, optional even
// parity, stop bit(s). The line idles high and all line-side outputs are registered.
module piso_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 1,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0
) (
    input  logic                  sr_clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  serial_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES + 1) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  accept;
    logic                  bit_end;
    logic                  line_val;

    assign ready_o = (state == IDLE);
    assign accept  = (state == IDLE) && load_i;
    assign bit_end = (bit_cnt == BIT_LAST);

    always_ff @(posedge sr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        line_val   = 1'b1;
        case (state)
            IDLE: begin
                if (load_i) begin
                    state_next = START;
                end
            end
            START: begin
                line_val = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                line_val = shift_reg[DATA_WIDTH-1];
                if (bit_end && (bit_idx == DATA_LAST)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                line_val = parity_bit;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end && (bit_idx == STOP_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line outputs follow the state one cycle later, so the start bit appears on the
    // edge after acceptance and done_o marks the first fully idle cycle.
    always_ff @(posedge sr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            serial_o   <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
        end else begin
            serial_o <= line_val;
            busy_o   <= (state != IDLE);
            done_o   <= (state == IDLE) && busy_o;
            if (accept) begin
                shift_reg  <= data_i;
                parity_bit <= ^data_i;
                bit_cnt    <= '0;
                bit_idx    <= '0;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    bit_cnt <= '0;
                    if (state == DATA) begin
                        shift_reg <= shift_reg << 1;
                    end
                    // bit_idx counts data bits in DATA and stop bits in STOP
                    if (state_next != state) begin
                        bit_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: three parameterisations (default, parity with two
// stop bits, four cycles per bit) checked cycle by cycle against a frame-level model.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [2:0] load;
    logic [2:0] ser;
    logic [2:0] rdy;
    logic [2:0] bsy;
    logic [2:0] dn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_tx u_def (
        .sr_clk_i(clk), .rst_i(rst), .load_i(load[0]), .data_i(data),
        .serial_o(ser[0]), .ready_o(rdy[0]), .busy_o(bsy[0]), .done_o(dn[0])
    );

    piso_tx #(.STOP_BITS(2), .PARITY_EN(1)) u_par (
        .sr_clk_i(clk), .rst_i(rst), .load_i(load[1]), .data_i(data),
        .serial_o(ser[1]), .ready_o(rdy[1]), .busy_o(bsy[1]), .done_o(dn[1])
    );

    piso_tx #(.BIT_CYCLES(4)) u_slow (
        .sr_clk_i(clk), .rst_i(rst), .load_i(load[2]), .data_i(data),
        .serial_o(ser[2]), .ready_o(rdy[2]), .busy_o(bsy[2]), .done_o(dn[2])
    );

    function automatic int bitCycles(int d);
        return (d == 2) ? 4 : 1;
    endfunction

    function automatic int stopBits(int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int parityEn(int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int frameLen(int d);
        return (1 + 8 + parityEn(d) + stopBits(d)) * bitCycles(d);
    endfunction

    // Expected line level j cycles after the accepting edge (j=1 is the first start cycle)
    function automatic logic modelLine(int d, logic [7:0] w, int j);
        int k;
        if (j < 1 || j > frameLen(d)) return 1'b1;
        k = (j - 1) / bitCycles(d);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[8-k];
        if (parityEn(d) != 0 && k == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkFrameCycle(input int d, input logic [7:0] w, input int j);
        int len;
        len = frameLen(d);
        checkOutput($sformatf("dut%0d w=%02h j=%0d serial", d, w, j), 32'(ser[d]), 32'(modelLine(d, w, j)));
        checkOutput($sformatf("dut%0d w=%02h j=%0d busy", d, w, j), 32'(bsy[d]), 32'(j >= 1 && j <= len));
        checkOutput($sformatf("dut%0d w=%02h j=%0d done", d, w, j), 32'(dn[d]), 32'(j == len + 1));
        checkOutput($sformatf("dut%0d w=%02h j=%0d ready", d, w, j), 32'(rdy[d]), 32'(j >= len));
    endtask

    task automatic checkIdle(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s dut%0d serial", tag, d), 32'(ser[d]), 32'd1);
            checkOutput($sformatf("%s dut%0d busy", tag, d), 32'(bsy[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d ready", tag, d), 32'(rdy[d]), 32'd1);
            checkOutput($sformatf("%s dut%0d done", tag, d), 32'(dn[d]), 32'd0);
        end
    endtask

    // One frame on all three DUTs; optionally a stray load of 8'hFF mid-frame
    task automatic applyStimulus(input logic [7:0] w, input bit spurious);
        @(negedge clk);
        data = w;
        load = 3'b111;
        @(posedge clk);
        #1;
        load = 3'b000;
        data = 8'($urandom);
        for (int j = 1; j <= 42; j++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) checkFrameCycle(d, w, j);
            if (spurious && j == 4) begin
                data = 8'hFF;
                load = 3'b111;
            end else if (j == 5) begin
                load = 3'b000;
                data = 8'($urandom);
            end
        end
    endtask

    // load held high on the default DUT across two frames
    task automatic backToBack(input logic [7:0] w1, input logic [7:0] w2);
        logic exp_line;
        @(negedge clk);
        data = w1;
        load[0] = 1'b1;
        @(posedge clk);
        #1;
        data = w2;
        for (int j = 1; j <= 23; j++) begin
            @(posedge clk);
            #1;
            if (j <= 10) exp_line = modelLine(0, w1, j);
            else if (j == 11) exp_line = 1'b1;
            else exp_line = modelLine(0, w2, j - 11);
            checkOutput($sformatf("b2b j=%0d serial", j), 32'(ser[0]), 32'(exp_line));
            checkOutput($sformatf("b2b j=%0d busy", j), 32'(bsy[0]),
                        32'((j >= 1 && j <= 10) || (j >= 12 && j <= 21)));
            checkOutput($sformatf("b2b j=%0d done", j), 32'(dn[0]), 32'(j == 11 || j == 22));
            if (j == 11) begin
                load[0] = 1'b0;
                data = 8'($urandom);
            end
        end
    endtask

    task automatic resetMidFrame();
        @(negedge clk);
        data = 8'h5A;
        load = 3'b111;
        @(posedge clk);
        #1;
        load = 3'b000;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkIdle("async reset");
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            checkIdle($sformatf("after reset c%0d", j));
        end
    endtask

    initial begin
        rst  = 1'b1;
        load = 3'b000;
        data = 8'h00;
        #12;
        checkIdle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkIdle("post reset");

        applyStimulus(8'hB6, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b1);
        backToBack(8'hA5, 8'h3C);
        resetMidFrame();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'($urandom), 1'($urandom_range(0, 1)));
        end
        backToBack(8'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
